// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and its video/ball datapath.
// The slave side is the controller; the master side is the datapath/environment.
interface pong_game_ctrl_if;
    logic       vsync;
    logic       start;
    logic [9:0] ball_x;
    logic       ball_reset;
    logic       ball_run;
    logic       serve_left;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;

    modport master (
        output vsync, start, ball_x,
        input  ball_reset, ball_run, serve_left, score1, score2, game_over, winner
    );

    modport slave (
        input  vsync, start, ball_x,
        output ball_reset, ball_run, serve_left, score1, score2, game_over, winner
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: serve countdown in frames, goal detection on frame ticks,
// score keeping with saturation and game-over detection. All outputs registered.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int LEFT_GOAL    = 20,
    parameter int RIGHT_GOAL   = 619
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);

    localparam logic [3:0] WIN_SCORE_C    = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_FRAMES_C = 8'(SERVE_FRAMES);
    localparam logic [9:0] LEFT_GOAL_C    = 10'(LEFT_GOAL);
    localparam logic [9:0] RIGHT_GOAL_C   = 10'(RIGHT_GOAL);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] frame_cnt_r, frame_cnt_s;
    logic [3:0] score1_r, score1_s;
    logic [3:0] score2_r, score2_s;
    logic       serve_left_r, serve_left_s;
    logic       winner_r, winner_s;
    logic       p2_scored_r, p2_scored_s;
    logic       ball_reset_r, ball_reset_s;
    logic       ball_run_r;
    logic       game_over_r;
    logic       vsync_r, vsync_q_r;
    logic       start_r, start_q_r;
    logic       frame_tick_s;
    logic       start_edge_s;
    logic [3:0] point_score_s;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v >= WIN_SCORE_C) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 4'd1;
        end
    endfunction

    assign frame_tick_s  = vsync_q_r & ~vsync_r;
    assign start_edge_s  = start_r & ~start_q_r;
    assign point_score_s = p2_scored_r ? score2_r : score1_r;

    // Next-state and next-register computation for the game FSM.
    always_comb begin
        state_s      = state_r;
        frame_cnt_s  = frame_cnt_r;
        score1_s     = score1_r;
        score2_s     = score2_r;
        serve_left_s = serve_left_r;
        winner_s     = winner_r;
        p2_scored_s  = p2_scored_r;
        ball_reset_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_s     = ST_SERVE;
                    score1_s    = 4'd0;
                    score2_s    = 4'd0;
                    frame_cnt_s = SERVE_FRAMES_C;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (frame_tick_s) begin
                    if (frame_cnt_r <= 8'd1) begin
                        frame_cnt_s  = 8'd0;
                        ball_reset_s = 1'b1;
                        state_s      = ST_PLAY;
                    end else begin
                        frame_cnt_s = frame_cnt_r - 8'd1;
                    end
                end else begin
                    state_s = ST_SERVE;
                end
            end
            ST_PLAY: begin
                // ball_x is only trusted at frame ticks, when the datapath has settled
                if (frame_tick_s && (bus.ball_x <= LEFT_GOAL_C)) begin
                    score2_s     = sat_inc(score2_r);
                    serve_left_s = 1'b1;
                    p2_scored_s  = 1'b1;
                    state_s      = ST_POINT;
                end else if (frame_tick_s && (bus.ball_x >= RIGHT_GOAL_C)) begin
                    score1_s     = sat_inc(score1_r);
                    serve_left_s = 1'b0;
                    p2_scored_s  = 1'b0;
                    state_s      = ST_POINT;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (point_score_s == WIN_SCORE_C) begin
                    state_s  = ST_OVER;
                    winner_s = p2_scored_r;
                end else begin
                    state_s     = ST_SERVE;
                    frame_cnt_s = SERVE_FRAMES_C;
                end
            end
            ST_OVER: begin
                if (start_edge_s) begin
                    state_s      = ST_SERVE;
                    score1_s     = 4'd0;
                    score2_s     = 4'd0;
                    serve_left_s = 1'b0;
                    winner_s     = 1'b0;
                    frame_cnt_s  = SERVE_FRAMES_C;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, scores, input edge detectors and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            frame_cnt_r  <= 8'd0;
            score1_r     <= 4'd0;
            score2_r     <= 4'd0;
            serve_left_r <= 1'b0;
            winner_r     <= 1'b0;
            p2_scored_r  <= 1'b0;
            ball_reset_r <= 1'b0;
            ball_run_r   <= 1'b0;
            game_over_r  <= 1'b0;
            vsync_r      <= 1'b0;
            vsync_q_r    <= 1'b0;
            start_r      <= 1'b0;
            start_q_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            frame_cnt_r  <= frame_cnt_s;
            score1_r     <= score1_s;
            score2_r     <= score2_s;
            serve_left_r <= serve_left_s;
            winner_r     <= winner_s;
            p2_scored_r  <= p2_scored_s;
            ball_reset_r <= ball_reset_s;
            ball_run_r   <= (state_s == ST_PLAY);
            game_over_r  <= (state_s == ST_OVER);
            vsync_r      <= bus.vsync;
            vsync_q_r    <= vsync_r;
            start_r      <= bus.start;
            start_q_r    <= start_r;
        end
    end

    assign bus.ball_reset = ball_reset_r;
    assign bus.ball_run   = ball_run_r;
    assign bus.serve_left = serve_left_r;
    assign bus.score1     = score1_r;
    assign bus.score2     = score2_r;
    assign bus.game_over  = game_over_r;
    assign bus.winner     = winner_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a frame/point-level game model is compared
// against the DUT every cycle, plus literal expectations at key moments.
module tb_pong_game_ctrl;

    localparam int TB_WIN   = 2;
    localparam int TB_SERVE = 60;
    localparam int TB_LEFT  = 20;
    localparam int TB_RIGHT = 619;

    localparam int M_IDLE  = 10;
    localparam int M_SERVE = 11;
    localparam int M_PLAY  = 12;
    localparam int M_POINT = 13;
    localparam int M_OVER  = 14;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .WIN_SCORE   (TB_WIN),
        .SERVE_FRAMES(TB_SERVE),
        .LEFT_GOAL   (TB_LEFT),
        .RIGHT_GOAL  (TB_RIGHT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;

    // game model state
    int m_mode = M_IDLE;
    int m_frames_left = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_serve_left = 0;
    int m_winner = 0;
    int m_last_p2 = 0;
    int m_ball_reset = 0;
    int m_vs1 = 0, m_vs2 = 0, m_st1 = 0, m_st2 = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one video frame: vsync high 2 cycles then low 2 cycles; one tick per frame
    task automatic frame(input int bx_hi, input int bx_lo);
        bus.vsync  = 1'b1;
        bus.ball_x = 10'(bx_hi);
        cycles(2);
        bus.vsync  = 1'b0;
        bus.ball_x = 10'(bx_lo);
        cycles(2);
    endtask

    task automatic frames(input int n, input int bx);
        for (int i = 0; i < n; i++) frame(bx, bx);
    endtask

    task automatic new_game();
        m_mode        = M_SERVE;
        m_frames_left = TB_SERVE;
        m_s1          = 0;
        m_s2          = 0;
    endtask

    // game model: evaluated at each clock edge from the input history
    initial begin
        bit tick, sedge;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode = M_IDLE; m_frames_left = 0; m_s1 = 0; m_s2 = 0;
                m_serve_left = 0; m_winner = 0; m_last_p2 = 0; m_ball_reset = 0;
                m_vs1 = 0; m_vs2 = 0; m_st1 = 0; m_st2 = 0;
            end else begin
                tick  = (m_vs2 == 1) && (m_vs1 == 0);
                sedge = (m_st1 == 1) && (m_st2 == 0);
                m_vs2 = m_vs1; m_vs1 = int'(bus.vsync);
                m_st2 = m_st1; m_st1 = int'(bus.start);
                m_ball_reset = 0;
                case (m_mode)
                    M_IDLE: if (sedge) new_game();
                    M_OVER: if (sedge) begin new_game(); m_serve_left = 0; end
                    M_SERVE: if (tick) begin
                        m_frames_left = m_frames_left - 1;
                        if (m_frames_left == 0) begin m_mode = M_PLAY; m_ball_reset = 1; end
                    end
                    M_PLAY: if (tick) begin
                        if (int'(bus.ball_x) <= TB_LEFT) begin
                            if (m_s2 < TB_WIN) m_s2 = m_s2 + 1;
                            m_serve_left = 1; m_last_p2 = 1; m_mode = M_POINT;
                        end else if (int'(bus.ball_x) >= TB_RIGHT) begin
                            if (m_s1 < TB_WIN) m_s1 = m_s1 + 1;
                            m_serve_left = 0; m_last_p2 = 0; m_mode = M_POINT;
                        end
                    end
                    M_POINT: begin
                        if ((m_last_p2 ? m_s2 : m_s1) == TB_WIN) begin
                            m_mode = M_OVER; m_winner = m_last_p2;
                        end else begin
                            m_mode = M_SERVE; m_frames_left = TB_SERVE;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    // per-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ball_reset) pulse_cnt++;
            check("ball_reset", int'(bus.ball_reset), m_ball_reset);
            check("ball_run", int'(bus.ball_run), int'(m_mode == M_PLAY));
            check("serve_left", int'(bus.serve_left), m_serve_left);
            check("score1", int'(bus.score1), m_s1);
            check("score2", int'(bus.score2), m_s2);
            check("game_over", int'(bus.game_over), int'(m_mode == M_OVER));
            if (m_mode == M_OVER) check("winner", int'(bus.winner), m_winner);
        end
    end

    // directed stimulus with literal expectations
    initial begin
        bus.vsync  = 1'b0;
        bus.start  = 1'b0;
        bus.ball_x = 10'd300;
        #1 reset = 1'b1;
        cycles(3);
        check("rst_score1", int'(bus.score1), 0);
        check("rst_ball_run", int'(bus.ball_run), 0);
        check("rst_game_over", int'(bus.game_over), 0);
        reset = 1'b0;

        // idle: goals ignored, no serve
        frames(2, 15);
        check("idle_score2", int'(bus.score2), 0);

        // start held high: one game start, 60-frame serve
        bus.start = 1'b1;
        cycles(2);
        frames(59, 300);
        check("serve_59_run", int'(bus.ball_run), 0);
        check("serve_59_pulses", pulse_cnt, 0);
        frame(300, 300);
        check("serve_60_reset", int'(bus.ball_reset), 1);
        cycles(1);
        check("serve_pulse_once", pulse_cnt, 1);
        check("play_run", int'(bus.ball_run), 1);

        // start pulses during play are ignored
        bus.start = 1'b0; cycles(3);
        bus.start = 1'b1; cycles(3);
        bus.start = 1'b0; cycles(2);
        check("play_start_ign", int'(bus.ball_run), 1);

        // left goal
        frame(15, 15);
        check("left_score2", int'(bus.score2), 1);
        check("left_serve_left", int'(bus.serve_left), 1);
        check("left_run", int'(bus.ball_run), 0);
        cycles(1);
        frames(59, 300);
        check("reserve_59", pulse_cnt, 1);
        frame(300, 300);
        check("reserve_60_reset", int'(bus.ball_reset), 1);

        // ball in goal between ticks only
        frame(15, 300);
        check("between_score2", int'(bus.score2), 1);
        check("between_run", int'(bus.ball_run), 1);

        // two right goals end the game
        frame(625, 625);
        check("right_score1", int'(bus.score1), 1);
        check("right_serve_left", int'(bus.serve_left), 0);
        cycles(1);
        frames(60, 300);
        frame(625, 625);
        cycles(2);
        check("over_score1", int'(bus.score1), 2);
        check("over_flag", int'(bus.game_over), 1);
        check("over_winner", int'(bus.winner), 0);
        check("over_run", int'(bus.ball_run), 0);

        // restart from game over
        bus.start = 1'b1; cycles(3);
        bus.start = 1'b0;
        check("restart_s1", int'(bus.score1), 0);
        check("restart_s2", int'(bus.score2), 0);
        check("restart_over", int'(bus.game_over), 0);
        frames(60, 300);
        frame(625, 625);
        cycles(1);
        frames(60, 300);
        check("pre_rst_s1", int'(bus.score1), 1);
        check("pre_rst_pulses", pulse_cnt, 5);

        // asynchronous reset in play
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_score1", int'(bus.score1), 0);
        check("arst_run", int'(bus.ball_run), 0);
        check("arst_reset_out", int'(bus.ball_reset), 0);
        cycles(2);
        reset = 1'b0;
        frames(62, 300);
        check("post_rst_pulses", pulse_cnt, 5);
        check("post_rst_run", int'(bus.ball_run), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
